// File: rtl/divider.sv
// rtl/divider.sv - sequential 8-bit unsigned restoring divider, one quotient bit per clock
// Optional zero-divisor short-cut and flag: DIVIDER_DIV_ZERO_CHECK_EN

module subtract (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] diff_o,
   output logic       ge_o
);
   logic [8:0] wide;

   assign wide   = {1'b0, a_i} - {1'b0, b_i};
   assign diff_o = wide[7:0];
   assign ge_o   = ~wide[8];
endmodule

module divider (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_valid,
   output logic       o_ready,
   input  logic [7:0] i_dividend,
   input  logic [7:0] i_divisor,
   output logic       o_valid,
   input  logic       i_ready,
   output logic [7:0] o_quotient,
   output logic [7:0] o_remainder,
   output logic       o_div_by_zero
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e     state_q, state_d;
   logic [7:0] q_q, q_d;
   logic [8:0] r_q, r_d;
   logic [7:0] d_q, d_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] quot_q, quot_d;
   logic [7:0] rem_q, rem_d;
   logic       valid_q, valid_d;
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
   logic       dbz_q, dbz_d;
`endif

   logic [8:0] s;
   logic [7:0] t;
   logic       ge;
   logic       fits;
   logic [8:0] r_iter;
   logic [7:0] q_iter;

   // Trial step: bring the next dividend bit into the partial remainder
   assign s = {r_q[7:0], q_q[7]};

   subtract u_sub (
      .a_i    (s[7:0]),
      .b_i    (d_q),
      .diff_o (t),
      .ge_o   (ge)
   );

   assign fits   = s[8] | ge;
   assign r_iter = fits ? {1'b0, t} : s;
   assign q_iter = {q_q[6:0], fits};

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      valid_d = valid_q;
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
      dbz_d   = dbz_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               q_d     = i_dividend;
               d_d     = i_divisor;
               r_d     = 9'd0;
               cnt_d   = 3'd0;
               state_d = BUSY;
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
               if (i_divisor == 8'd0) begin
                  state_d = DONE;
                  quot_d  = 8'hFF;
                  rem_d   = i_dividend;
                  dbz_d   = 1'b1;
                  valid_d = 1'b1;
               end
`endif
            end
         end
         BUSY: begin
            q_d   = q_iter;
            r_d   = r_iter;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = DONE;
               quot_d  = q_iter;
               rem_d   = r_iter[7:0];
               valid_d = 1'b1;
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
               dbz_d   = 1'b0;
`endif
            end
         end
         DONE: begin
            if (i_ready) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         q_q     <= 8'd0;
         r_q     <= 9'd0;
         d_q     <= 8'd0;
         cnt_q   <= 3'd0;
         quot_q  <= 8'd0;
         rem_q   <= 8'd0;
         valid_q <= 1'b0;
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
         dbz_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
         dbz_q   <= dbz_d;
`endif
      end
   end

   assign o_ready     = (state_q == IDLE);
   assign o_valid     = valid_q;
   assign o_quotient  = quot_q;
   assign o_remainder = rem_q;
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
   assign o_div_by_zero = dbz_q;
`else
   assign o_div_by_zero = 1'b0;
`endif
endmodule
